// File: rtl/drm_bridge_pkg.sv
// Shared field positions and response record for the DRM stream bridge.
package drm_bridge_pkg;

    localparam int IN_DAT     = 0;
    localparam int IN_WE      = 1;
    localparam int IN_ADR_LSB = 2;
    localparam int IN_CYC     = 4;
    localparam int IN_CS      = 5;
    localparam int IN_CH_LSB  = 8;

    typedef struct packed {
        logic [15:0] intr_map;
        logic [7:0]  ch;
        logic        ch_err;
        logic        ack;
        logic        intr;
        logic        sta;
        logic        dat;
    } resp_t;

    // Outbound word: [31:16] intr map, [15:8] ch, [7:5] zero, [4] ch_err, [3:0] ack/intr/sta/dat
    function automatic logic [31:0] pack_resp(input resp_t r);
        return {r.intr_map, r.ch, 3'b000, r.ch_err, r.ack, r.intr, r.sta, r.dat};
    endfunction

endpackage

// File: rtl/drm_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered show-ahead head word.
module drm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        // The next head is the word being written when it lands exactly at the new read pointer.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
        rd_data = rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/drm_uip_stream_mux.sv
// DRM controller stream pair to NUM_CH activator bus-slave ports, with a
// two-stage strobe/response pipeline, response FIFO and outbound stall watchdog.
module drm_uip_stream_mux
    import drm_bridge_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          drm_aclk,
    input  logic                          drm_arstn,
    output logic                          drm_to_uip_tready,
    input  logic                          drm_to_uip_tvalid,
    input  logic [31:0]                   drm_to_uip_tdata,
    input  logic                          uip_to_drm_tready,
    output logic                          uip_to_drm_tvalid,
    output logic [31:0]                   uip_to_drm_tdata,
    output logic [NUM_CH-1:0]             act_cs,
    output logic                          act_cyc,
    output logic                          act_we,
    output logic                          act_dat,
    output logic [1:0]                    act_adr,
    input  logic [NUM_CH-1:0]             act_ack,
    input  logic [NUM_CH-1:0]             act_sta,
    input  logic [NUM_CH-1:0]             act_intr,
    input  logic [NUM_CH-1:0]             act_odat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ch_err,
    output logic                          stall_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    NUM_CH_B  = 8'(NUM_CH);
    localparam logic [LW:0]   DEPTH_B   = (LW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);

    logic              rdy_en_q, rdy_en_d;
    logic              s0_vld_q, s0_vld_d;
    logic [15:0]       s0_word_q, s0_word_d;
    logic              s1_vld_q, s1_vld_d;
    logic [7:0]        s1_ch_q, s1_ch_d;
    logic [NUM_CH-1:0] act_cs_q, act_cs_d;
    logic              act_cyc_q, act_cyc_d;
    logic [1:0]        act_adr_q, act_adr_d;
    logic              act_we_q, act_we_d;
    logic              act_dat_q, act_dat_d;
    logic              ch_err_q, ch_err_d;
    logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic              stall_err_q, stall_err_d;

    logic              acc, in_bad, s0_bad, s1_bad;
    logic [LW:0]       occ;
    logic              fifo_pop, fifo_empty, fifo_full;
    resp_t             resp, head;
    logic              unused_bits;

    drm_sync_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (drm_aclk),
        .rst_n   (drm_arstn),
        .push    (s1_vld_q),
        .pop     (fifo_pop),
        .wr_data (resp),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level),
        .rd_data (head)
    );

    always_comb begin
        // Words still in the pipeline are counted so the FIFO can never overflow.
        occ = {1'b0, fifo_level} + {{LW{1'b0}}, s0_vld_q} + {{LW{1'b0}}, s1_vld_q};
        drm_to_uip_tready = rdy_en_q && (occ < DEPTH_B);
        acc    = drm_to_uip_tvalid && drm_to_uip_tready;
        in_bad = drm_to_uip_tdata[IN_CH_LSB +: 8] >= NUM_CH_B;
        s0_bad = s0_word_q[IN_CH_LSB +: 8] >= NUM_CH_B;
        s1_bad = s1_ch_q >= NUM_CH_B;

        rdy_en_d  = 1'b1;
        s0_vld_d  = acc;
        s0_word_d = acc ? drm_to_uip_tdata[15:0] : s0_word_q;
        s1_vld_d  = s0_vld_q;
        s1_ch_d   = s0_vld_q ? s0_word_q[IN_CH_LSB +: 8] : s1_ch_q;

        act_cs_d  = '0;
        act_cyc_d = 1'b0;
        act_adr_d = act_adr_q;
        act_we_d  = act_we_q;
        act_dat_d = act_dat_q;
        if (s0_vld_q) begin
            act_cyc_d = s0_word_q[IN_CYC];
            act_adr_d = s0_word_q[IN_ADR_LSB +: 2];
            act_we_d  = s0_word_q[IN_WE];
            act_dat_d = s0_word_q[IN_DAT];
            if (s0_word_q[IN_CS] && !s0_bad) begin
                act_cs_d[s0_word_q[IN_CH_LSB +: CH_W]] = 1'b1;
            end
        end

        resp          = '0;
        resp.intr_map = 16'(act_intr);
        resp.ch       = s1_ch_q;
        resp.ch_err   = s1_bad;
        resp.intr     = |act_intr;
        if (!s1_bad) begin
            resp.ack = act_ack[s1_ch_q[CH_W-1:0]];
            resp.sta = act_sta[s1_ch_q[CH_W-1:0]];
            resp.dat = act_odat[s1_ch_q[CH_W-1:0]];
        end

        uip_to_drm_tvalid = !fifo_empty;
        uip_to_drm_tdata  = pack_resp(head);
        fifo_pop          = uip_to_drm_tready && uip_to_drm_tvalid;

        stall_cnt_d = stall_cnt_q;
        if (!uip_to_drm_tvalid || fifo_pop) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        stall_err_d = stall_err_q | (stall_cnt_d == STALL_MAX);
        ch_err_d    = ch_err_q | (acc && in_bad);

        act_cs    = act_cs_q;
        act_cyc   = act_cyc_q;
        act_adr   = act_adr_q;
        act_we    = act_we_q;
        act_dat   = act_dat_q;
        ch_err    = ch_err_q;
        stall_err = stall_err_q;

        unused_bits = ^{drm_to_uip_tdata[31:16], s0_word_q[7:6], fifo_full};
    end

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            rdy_en_q    <= 1'b0;
            s0_vld_q    <= 1'b0;
            s0_word_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            act_cs_q    <= '0;
            act_cyc_q   <= 1'b0;
            act_adr_q   <= '0;
            act_we_q    <= 1'b0;
            act_dat_q   <= 1'b0;
            ch_err_q    <= 1'b0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            s0_vld_q    <= s0_vld_d;
            s0_word_q   <= s0_word_d;
            s1_vld_q    <= s1_vld_d;
            s1_ch_q     <= s1_ch_d;
            act_cs_q    <= act_cs_d;
            act_cyc_q   <= act_cyc_d;
            act_adr_q   <= act_adr_d;
            act_we_q    <= act_we_d;
            act_dat_q   <= act_dat_d;
            ch_err_q    <= ch_err_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

endmodule

// File: tb/tb_drm_uip_stream_mux.sv
// Self-checking bench: queue-based transaction model plus directed literal checks and random traffic.
module tb_drm_uip_stream_mux;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              drm_to_uip_tready;
    logic              drm_to_uip_tvalid = 1'b0;
    logic [31:0]       drm_to_uip_tdata = '0;
    logic              uip_to_drm_tready = 1'b0;
    logic              uip_to_drm_tvalid;
    logic [31:0]       uip_to_drm_tdata;
    logic [NUM_CH-1:0] act_cs;
    logic              act_cyc, act_we, act_dat;
    logic [1:0]        act_adr;
    logic [NUM_CH-1:0] act_ack = '0, act_sta = '0, act_intr = '0, act_odat = '0;
    logic [3:0]        fifo_level;
    logic              ch_err, stall_err;

    always #5 clk = ~clk;

    drm_uip_stream_mux #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .drm_aclk          (clk),
        .drm_arstn         (rst_n),
        .drm_to_uip_tready (drm_to_uip_tready),
        .drm_to_uip_tvalid (drm_to_uip_tvalid),
        .drm_to_uip_tdata  (drm_to_uip_tdata),
        .uip_to_drm_tready (uip_to_drm_tready),
        .uip_to_drm_tvalid (uip_to_drm_tvalid),
        .uip_to_drm_tdata  (uip_to_drm_tdata),
        .act_cs            (act_cs),
        .act_cyc           (act_cyc),
        .act_we            (act_we),
        .act_dat           (act_dat),
        .act_adr           (act_adr),
        .act_ack           (act_ack),
        .act_sta           (act_sta),
        .act_intr          (act_intr),
        .act_odat          (act_odat),
        .fifo_level        (fifo_level),
        .ch_err            (ch_err),
        .stall_err         (stall_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] w;
        int          age;
    } pend_t;

    pend_t             pend[$];
    logic [31:0]       outq[$];
    bit                m_rdy_en, m_stall_err, m_ch_err;
    int                m_stall;
    logic [NUM_CH-1:0] m_cs;
    logic              m_cyc, m_we, m_dat;
    logic [1:0]        m_adr;

    function automatic logic [31:0] expect_resp(input logic [7:0] ch);
        logic [31:0] r;
        logic [1:0]  c;
        c = ch[1:0];
        r = {12'h000, act_intr, ch, 8'h00};
        if (act_intr != '0) r[2] = 1'b1;
        if (ch >= 8'(NUM_CH)) begin
            r[4] = 1'b1;
        end else begin
            r[3] = act_ack[c];
            r[1] = act_sta[c];
            r[0] = act_odat[c];
        end
        return r;
    endfunction

    function automatic bit m_tready();
        return m_rdy_en && ((outq.size() + pend.size()) < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit          vld_pre, pop, acc;
        logic [15:0] w0;
        if (!rst_n) begin
            pend.delete();
            outq.delete();
            m_rdy_en = 0; m_stall = 0; m_stall_err = 0; m_ch_err = 0;
            m_cs = '0; m_cyc = 0; m_we = 0; m_dat = 0; m_adr = '0;
        end else begin
            vld_pre = outq.size() > 0;
            pop     = vld_pre && uip_to_drm_tready;
            acc     = drm_to_uip_tvalid && m_tready();
            if (!vld_pre || pop) m_stall = 0;
            else if (m_stall < TMO) m_stall++;
            if (m_stall >= TMO) m_stall_err = 1;
            if (pop) void'(outq.pop_front());
            if (acc && drm_to_uip_tdata[15:8] >= 8'(NUM_CH)) m_ch_err = 1;
            if (pend.size() > 0 && pend[0].age == 1) begin
                w0 = pend[0].w;
                outq.push_back(expect_resp(w0[15:8]));
                void'(pend.pop_front());
            end
            m_cs  = '0;
            m_cyc = 0;
            if (pend.size() > 0) begin
                w0    = pend[0].w;
                m_cyc = w0[4];
                m_adr = w0[3:2];
                m_we  = w0[1];
                m_dat = w0[0];
                if (w0[5] && w0[15:8] < 8'(NUM_CH)) m_cs[w0[9:8]] = 1'b1;
                pend[0].age = 1;
            end
            if (acc) pend.push_back('{w: drm_to_uip_tdata[15:0], age: 0});
            m_rdy_en = 1;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tready", 32'(drm_to_uip_tready), 32'(m_tready()));
            chk("tvalid", 32'(uip_to_drm_tvalid), 32'(outq.size() > 0));
            if (outq.size() > 0) chk("tdata", uip_to_drm_tdata, outq[0]);
            else if (!rst_n)     chk("tdata_rst", uip_to_drm_tdata, 32'h0);
            chk("act_cs", 32'(act_cs), 32'(m_cs));
            chk("act_cyc", 32'(act_cyc), 32'(m_cyc));
            chk("act_adr", 32'(act_adr), 32'(m_adr));
            chk("act_we", 32'(act_we), 32'(m_we));
            chk("act_dat", 32'(act_dat), 32'(m_dat));
            chk("fifo_level", 32'(fifo_level), 32'(outq.size()));
            chk("ch_err", 32'(ch_err), 32'(m_ch_err));
            chk("stall_err", 32'(stall_err), 32'(m_stall_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus with literal pins ----------------
    initial begin
        int nacc;
        drm_to_uip_tvalid = 1'b1;
        cmp_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(drm_to_uip_tready), 32'h0);
        chk("rst_tvalid", 32'(uip_to_drm_tvalid), 32'h0);
        chk("rst_cs", 32'(act_cs), 32'h0);
        step();
        rst_n = 1'b1;
        drm_to_uip_tvalid = 1'b0;
        @(negedge clk);
        chk("rel_tready_0", 32'(drm_to_uip_tready), 32'h0);
        step();
        @(negedge clk);
        chk("rel_tready_1", 32'(drm_to_uip_tready), 32'h1);

        // single write to channel 2
        step();
        drm_to_uip_tdata = 32'h0000_0232; drm_to_uip_tvalid = 1'b1;
        act_ack = 4'b0100; uip_to_drm_tready = 1'b1;
        step();
        drm_to_uip_tvalid = 1'b0;
        @(negedge clk);
        chk("wr_cs_T", 32'(act_cs), 32'h0);
        step();
        @(negedge clk);
        chk("wr_cs_T1", 32'(act_cs), 32'h4);
        chk("wr_cyc_T1", 32'(act_cyc), 32'h1);
        chk("wr_we_T1", 32'(act_we), 32'h1);
        chk("wr_tvalid_T1", 32'(uip_to_drm_tvalid), 32'h0);
        step();
        @(negedge clk);
        chk("wr_tvalid_T2", 32'(uip_to_drm_tvalid), 32'h1);
        chk("wr_tdata_T2", uip_to_drm_tdata, 32'h0000_0208);
        chk("wr_cs_T2", 32'(act_cs), 32'h0);
        repeat (4) step();

        // backpressure: 12 offered words, only DEPTH accepted
        uip_to_drm_tready = 1'b0;
        act_ack = 4'b1010; act_sta = 4'b0110; act_intr = 4'b0001; act_odat = 4'b1100;
        nacc = 0;
        drm_to_uip_tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drm_to_uip_tdata = {16'h0, 8'(i % 4), 4'h3, 4'($urandom_range(0, 15))};
            @(negedge clk);
            if (drm_to_uip_tready) nacc++;
            step();
        end
        drm_to_uip_tvalid = 1'b0;
        chk("bp_accepted", 32'(nacc), 32'd8);
        repeat (3) step();
        @(negedge clk);
        chk("bp_level", 32'(fifo_level), 32'd8);
        chk("bp_tready", 32'(drm_to_uip_tready), 32'h0);
        uip_to_drm_tready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("bp_drained", 32'(fifo_level), 32'h0);

        // bad channel
        act_intr = '0;
        drm_to_uip_tdata = 32'h0000_0530; drm_to_uip_tvalid = 1'b1;
        step();
        drm_to_uip_tvalid = 1'b0;
        step();
        @(negedge clk);
        chk("bad_cs", 32'(act_cs), 32'h0);
        chk("bad_ch_err", 32'(ch_err), 32'h1);
        step();
        @(negedge clk);
        chk("bad_tdata", uip_to_drm_tdata, 32'h0000_0510);
        repeat (5) step();
        chk("bad_ch_err_sticky", 32'(ch_err), 32'h1);

        // watchdog with a pop resetting the counter at stall cycle 15
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("wd_clear", 32'(stall_err), 32'h0);
        chk("wd_ch_err_clear", 32'(ch_err), 32'h0);
        uip_to_drm_tready = 1'b0;
        drm_to_uip_tdata = 32'h0000_0130; drm_to_uip_tvalid = 1'b1;
        repeat (2) step();
        drm_to_uip_tvalid = 1'b0;
        step();
        repeat (14) step();
        @(negedge clk);
        chk("wd_14", 32'(stall_err), 32'h0);
        uip_to_drm_tready = 1'b1;
        step();
        uip_to_drm_tready = 1'b0;
        repeat (15) step();
        @(negedge clk);
        chk("wd_15_after_pop", 32'(stall_err), 32'h0);
        step();
        @(negedge clk);
        chk("wd_16", 32'(stall_err), 32'h1);

        // mid-stream reset with five queued responses
        uip_to_drm_tready = 1'b1;
        repeat (3) step();
        uip_to_drm_tready = 1'b0;
        drm_to_uip_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drm_to_uip_tdata = {16'h0, 8'(i % 4), 8'h3A};
            step();
        end
        drm_to_uip_tvalid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("mr_level5", 32'(fifo_level), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_level0", 32'(fifo_level), 32'h0);
        chk("mr_tvalid0", 32'(uip_to_drm_tvalid), 32'h0);
        step();
        rst_n = 1'b1;
        uip_to_drm_tready = 1'b1;
        repeat (6) step();
        chk("mr_no_stale", 32'(uip_to_drm_tvalid), 32'h0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            drm_to_uip_tvalid = ($urandom_range(0, 3) != 0);
            drm_to_uip_tdata  = $urandom;
            drm_to_uip_tdata[15:8] = 8'($urandom_range(0, 5));
            if ((c % 400) < 60) uip_to_drm_tready = 1'b0;
            else uip_to_drm_tready = $urandom_range(0, 1) == 1;
            act_ack  = 4'($urandom);
            act_sta  = 4'($urandom);
            act_intr = 4'($urandom);
            act_odat = 4'($urandom);
            if ((c % 1000) == 500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        drm_to_uip_tvalid = 1'b0;
        repeat (2) step();
        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
